axi_ni_response_header_queue: RTL and testbench

Parametrised response-header capture and decode stage for the AXI initiator NI. It assembles a multi-flit response header from the NoC, decodes source, response type, lock and transaction ID, and buffers up to `QUEUE_DEPTH` decoded headers behind a valid/ready interface to the AXI response generator. Unlike the single-header register, it keeps its own flit counter, applies back-pressure, supports abort of a partial header, and exposes the raw response type and a decode-error flag.

---
 rtl/axi_ni_response_header_queue_pkg.sv | 20 ++
 rtl/axi_ni_response_header_queue_if.sv | 36 +++
 rtl/axi_ni_response_header_queue_fifo.sv | 61 ++++++
 rtl/axi_ni_response_header_queue.sv | 127 ++++++++++++
 tb/tb_axi_ni_response_header_queue.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_ni_response_header_queue_pkg.sv
// rtl/axi_ni_response_header_queue_pkg.sv - shared field widths, response-type encodings and header sizing
package axi_ni_response_header_queue_pkg;

    localparam int FTYPEWD          = 2;
    localparam int ROUTEWD          = 8;
    localparam int SOURCEWD         = 8;
    localparam int PACKETRESPTYPEWD = 3;
    localparam int PACKETTRANSIDWD  = 8;

    localparam logic [PACKETRESPTYPEWD-1:0] PACKETRESPTYPEREAD    = 3'd1;
    localparam logic [PACKETRESPTYPEWD-1:0] PACKETRESPTYPEEXREAD  = 3'd2;
    localparam logic [PACKETRESPTYPEWD-1:0] PACKETRESPTYPEWRITE   = 3'd3;
    localparam logic [PACKETRESPTYPEWD-1:0] PACKETRESPTYPEEXWRITE = 3'd4;

    // Header length once the flit-type field of every flit has been stripped.
    function automatic int hdr_bits(input int hdr_flits, input int flit_width, input int ftype_width);
        return hdr_flits * (flit_width - ftype_width);
    endfunction

endpackage

// File: rtl/axi_ni_response_header_queue_if.sv
// rtl/axi_ni_response_header_queue_if.sv - NoC header-flit and decoded-header handshake bundle
interface axi_ni_response_header_queue_if #(
    parameter int FLIT_WIDTH     = 32,
    parameter int SOURCE_WIDTH   = 8,
    parameter int RESPTYPE_WIDTH = 3,
    parameter int TRANSID_WIDTH  = 8,
    parameter int QUEUE_DEPTH    = 4
) ();
    localparam int OCC_WIDTH = $clog2(QUEUE_DEPTH) + 1;

    logic                      hdr_valid;
    logic [FLIT_WIDTH-1:0]     hdr_flit;
    logic                      hdr_ready;
    logic                      abort;
    logic                      out_valid;
    logic                      out_ready;
    logic [SOURCE_WIDTH-1:0]   out_source;
    logic [RESPTYPE_WIDTH-1:0] out_resp_type;
    logic                      out_is_read;
    logic                      out_is_locked;
    logic [TRANSID_WIDTH-1:0]  out_trans_id;
    logic                      out_type_err;
    logic [OCC_WIDTH-1:0]      occupancy;

    modport slave (
        input  hdr_valid, hdr_flit, abort, out_ready,
        output hdr_ready, out_valid, out_source, out_resp_type, out_is_read,
               out_is_locked, out_trans_id, out_type_err, occupancy
    );

    modport master (
        output hdr_valid, hdr_flit, abort, out_ready,
        input  hdr_ready, out_valid, out_source, out_resp_type, out_is_read,
               out_is_locked, out_trans_id, out_type_err, occupancy
    );
endinterface

// File: rtl/axi_ni_response_header_queue_fifo.sv
// rtl/axi_ni_response_header_queue_fifo.sv - ni_sync_fifo: register-based synchronous FIFO with count
module ni_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_rd;
    logic             do_wr;

    // A write into a full FIFO is allowed only when the head leaves in the same cycle.
    always_comb begin
        do_rd = rd_en && (cnt != '0);
        do_wr = wr_en && ((cnt != FULL_CNT) || do_rd);
    end

    // Storage, pointers and count; entries are cleared so the head reads zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign count   = cnt;
endmodule

// File: rtl/axi_ni_response_header_queue.sv
// rtl/axi_ni_response_header_queue.sv - multi-flit response header assembly, decode and queueing
module axi_ni_response_header_queue
    import axi_ni_response_header_queue_pkg::*;
#(
    parameter int FLIT_WIDTH     = 32,
    parameter int FTYPE_WIDTH    = FTYPEWD,
    parameter int HDR_FLITS      = 2,
    parameter int ROUTE_WIDTH    = ROUTEWD,
    parameter int SOURCE_WIDTH   = SOURCEWD,
    parameter int RESPTYPE_WIDTH = PACKETRESPTYPEWD,
    parameter int TRANSID_WIDTH  = PACKETTRANSIDWD,
    parameter int TYPE_BASE      = 0,
    parameter int TRANSID_BASE   = 4,
    parameter int QUEUE_DEPTH    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    axi_ni_response_header_queue_if.slave  bus
);
    localparam int PAYLOAD_W = FLIT_WIDTH - FTYPE_WIDTH;
    localparam int HDR_W     = hdr_bits(HDR_FLITS, FLIT_WIDTH, FTYPE_WIDTH);
    localparam int S         = SOURCE_WIDTH + ROUTE_WIDTH;
    localparam int CNT_W     = (HDR_FLITS > 1) ? $clog2(HDR_FLITS) : 1;
    localparam int OCC_W     = $clog2(QUEUE_DEPTH) + 1;
    localparam int ENTRY_W   = SOURCE_WIDTH + RESPTYPE_WIDTH + TRANSID_WIDTH + 3;
    localparam logic [CNT_W-1:0] LAST_FLIT = CNT_W'(HDR_FLITS - 1);

    typedef struct packed {
        logic                      type_err;
        logic                      is_locked;
        logic                      is_read;
        logic [TRANSID_WIDTH-1:0]  trans_id;
        logic [RESPTYPE_WIDTH-1:0] resp_type;
        logic [SOURCE_WIDTH-1:0]   source;
    } entry_t;

    logic [CNT_W-1:0]          flit_cnt;
    logic [HDR_W-1:0]          asm_q;
    logic [PAYLOAD_W-1:0]      payload;
    logic [HDR_W-1:0]          full_hdr;
    logic [RESPTYPE_WIDTH-1:0] resp_type;
    logic                      t_read;
    logic                      t_exread;
    logic                      t_write;
    logic                      t_exwrite;
    entry_t                    entry_in;
    entry_t                    entry_out;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [OCC_W-1:0]          fifo_count;
    logic                      is_last;
    logic                      accept;
    logic                      push;
    logic                      unused_hdr_bits;

    assign payload = bus.hdr_flit[FLIT_WIDTH-1:FTYPE_WIDTH];
    assign is_last = (flit_cnt == LAST_FLIT);

    // The final slice comes straight from the incoming flit so the header decodes on the accepting edge.
    always_comb begin
        full_hdr = asm_q;
        full_hdr[(HDR_FLITS-1)*PAYLOAD_W +: PAYLOAD_W] = payload;
    end

    // Decode source, type and ID from the assembled header into a queue entry.
    always_comb begin
        resp_type          = full_hdr[TYPE_BASE+S +: RESPTYPE_WIDTH];
        t_read             = (resp_type == RESPTYPE_WIDTH'(PACKETRESPTYPEREAD));
        t_exread           = (resp_type == RESPTYPE_WIDTH'(PACKETRESPTYPEEXREAD));
        t_write            = (resp_type == RESPTYPE_WIDTH'(PACKETRESPTYPEWRITE));
        t_exwrite          = (resp_type == RESPTYPE_WIDTH'(PACKETRESPTYPEEXWRITE));
        entry_in           = '0;
        entry_in.source    = full_hdr[ROUTE_WIDTH +: SOURCE_WIDTH];
        entry_in.resp_type = resp_type;
        entry_in.trans_id  = full_hdr[TRANSID_BASE+S +: TRANSID_WIDTH];
        entry_in.is_read   = t_read || t_exread;
        entry_in.is_locked = t_exread || t_exwrite;
        entry_in.type_err  = !(t_read || t_exread || t_write || t_exwrite);
    end

    // Only the last flit needs queue space; a pop in the same cycle frees it, hence the out_ready path.
    always_comb begin
        bus.hdr_ready = !bus.abort && (!is_last || !fifo_full || bus.out_ready);
        accept        = bus.hdr_valid && bus.hdr_ready;
        push          = accept && is_last;
    end

    // Flit counter and assembly register; abort restarts assembly without touching the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            flit_cnt <= '0;
            asm_q    <= '0;
        end else if (bus.abort) begin
            flit_cnt <= '0;
        end else if (accept) begin
            asm_q[flit_cnt*PAYLOAD_W +: PAYLOAD_W] <= payload;
            flit_cnt <= is_last ? '0 : flit_cnt + 1'b1;
        end
    end

    ni_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (entry_in),
        .rd_en   (bus.out_ready),
        .rd_data (entry_out),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign bus.out_valid     = !fifo_empty;
    assign bus.out_source    = entry_out.source;
    assign bus.out_resp_type = entry_out.resp_type;
    assign bus.out_is_read   = entry_out.is_read;
    assign bus.out_is_locked = entry_out.is_locked;
    assign bus.out_trans_id  = entry_out.trans_id;
    assign bus.out_type_err  = entry_out.type_err;
    assign bus.occupancy     = fifo_count;

    // Route, padding and flit-type bits are carried but never decoded here.
    assign unused_hdr_bits = ^{full_hdr, bus.hdr_flit[FTYPE_WIDTH-1:0]};
endmodule

// File: tb/tb_axi_ni_response_header_queue.sv
// tb/tb_axi_ni_response_header_queue.sv - directed and scoreboarded bench for the response header queue
module tb_axi_ni_response_header_queue;
    import axi_ni_response_header_queue_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    axi_ni_response_header_queue_if #(.FLIT_WIDTH(32), .SOURCE_WIDTH(8), .RESPTYPE_WIDTH(3),
                                      .TRANSID_WIDTH(8), .QUEUE_DEPTH(4)) bus0 ();
    axi_ni_response_header_queue_if #(.FLIT_WIDTH(64), .SOURCE_WIDTH(8), .RESPTYPE_WIDTH(3),
                                      .TRANSID_WIDTH(8), .QUEUE_DEPTH(8)) bus1 ();

    axi_ni_response_header_queue #(.FLIT_WIDTH(32), .HDR_FLITS(2), .QUEUE_DEPTH(4)) u0 (
        .clk (clk), .rst (rst), .bus (bus0.slave)
    );
    axi_ni_response_header_queue #(.FLIT_WIDTH(64), .HDR_FLITS(1), .QUEUE_DEPTH(8)) u1 (
        .clk (clk), .rst (rst), .bus (bus1.slave)
    );

    typedef struct {
        logic [7:0] src;
        logic [2:0] t;
        logic [7:0] id;
        logic [7:0] route;
    } item_t;

    item_t sb[$];

    function automatic logic [63:0] mk(input logic [7:0] src, input logic [2:0] t,
                                       input logic [7:0] id, input logic [7:0] route);
        logic [63:0] h;
        h        = '0;
        h[7:0]   = route;
        h[15:8]  = src;
        h[18:16] = t;
        h[27:20] = id;
        return h;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_flit(input logic [31:0] f);
        int n;
        bus0.hdr_valid = 1'b1;
        bus0.hdr_flit  = f;
        #1;
        n = 0;
        while (bus0.hdr_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL send_flit_timeout: hdr_ready=%b after %0d cycles, required 1", bus0.hdr_ready, n);
        end
        @(posedge clk);
        #1;
        bus0.hdr_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [63:0] h);
        send_flit({h[29:0], 2'b01});
        send_flit({h[59:30], 2'b10});
    endtask

    task automatic pop0;
        bus0.out_ready = 1'b1;
        tick();
        bus0.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        checks += 7;
        if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", bus0.out_valid); end
        if (bus0.occupancy !== 3'd0) begin errors++; $display("FAIL reset_occupancy: got %0d, required 0", bus0.occupancy); end
        if (bus0.hdr_ready !== 1'b1) begin errors++; $display("FAIL reset_hdr_ready: got %b, required 1", bus0.hdr_ready); end
        if (bus0.out_source !== 8'h00) begin errors++; $display("FAIL reset_source: got %h, required 00", bus0.out_source); end
        if (bus0.out_trans_id !== 8'h00) begin errors++; $display("FAIL reset_trans_id: got %h, required 00", bus0.out_trans_id); end
        if (bus0.out_type_err !== 1'b0) begin errors++; $display("FAIL reset_type_err: got %b, required 0", bus0.out_type_err); end
        if (bus1.out_valid !== 1'b0 || bus1.occupancy !== 4'd0) begin
            errors++; $display("FAIL reset_sweep_dut: out_valid=%b occupancy=%0d, required 0/0", bus1.out_valid, bus1.occupancy);
        end
        rst = 1'b0;
    endtask

    task automatic test_single;
        logic [63:0] h;
        h = mk(8'h2A, PACKETRESPTYPEREAD, 8'h05, 8'h11);
        send_flit({h[29:0], 2'b01});
        checks++;
        if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b, required 0", bus0.out_valid); end
        send_flit({h[59:30], 2'b10});
        checks += 8;
        if (bus0.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b, required 1", bus0.out_valid); end
        if (bus0.out_source !== 8'h2A) begin errors++; $display("FAIL single_source: got %h, required 2a", bus0.out_source); end
        if (bus0.out_resp_type !== 3'd1) begin errors++; $display("FAIL single_resp_type: got %0d, required 1", bus0.out_resp_type); end
        if (bus0.out_is_read !== 1'b1) begin errors++; $display("FAIL single_is_read: got %b, required 1", bus0.out_is_read); end
        if (bus0.out_is_locked !== 1'b0) begin errors++; $display("FAIL single_is_locked: got %b, required 0", bus0.out_is_locked); end
        if (bus0.out_trans_id !== 8'h05) begin errors++; $display("FAIL single_trans_id: got %h, required 05", bus0.out_trans_id); end
        if (bus0.out_type_err !== 1'b0) begin errors++; $display("FAIL single_type_err: got %b, required 0", bus0.out_type_err); end
        if (bus0.occupancy !== 3'd1) begin errors++; $display("FAIL single_occupancy: got %0d, required 1", bus0.occupancy); end
        pop0();
        checks++;
        if (bus0.out_valid !== 1'b0 || bus0.occupancy !== 3'd0) begin
            errors++; $display("FAIL single_pop: out_valid=%b occupancy=%0d, required 0/0", bus0.out_valid, bus0.occupancy);
        end
        pop0();
        checks++;
        if (bus0.occupancy !== 3'd0) begin errors++; $display("FAIL pop_on_empty: occupancy=%0d, required 0", bus0.occupancy); end
    endtask

    task automatic test_types;
        logic [2:0] t   [3] = '{3'd4, 3'd2, 3'd6};
        logic [7:0] src [3] = '{8'h13, 8'h44, 8'h05};
        logic [7:0] id  [3] = '{8'h7A, 8'h81, 8'h00};
        logic       rd  [3] = '{1'b0, 1'b1, 1'b0};
        logic       lk  [3] = '{1'b1, 1'b1, 1'b0};
        logic       er  [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) send_hdr(mk(src[i], t[i], id[i], 8'hC3));
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus0.out_valid !== 1'b1 || bus0.out_source !== src[i] || bus0.out_resp_type !== t[i] ||
                bus0.out_trans_id !== id[i] || bus0.out_is_read !== rd[i] || bus0.out_is_locked !== lk[i] ||
                bus0.out_type_err !== er[i]) begin
                errors++;
                $display("FAIL types_%0d: v=%b src=%h t=%0d id=%h rd=%b lk=%b err=%b, required v=1 src=%h t=%0d id=%h rd=%b lk=%b err=%b",
                         i, bus0.out_valid, bus0.out_source, bus0.out_resp_type, bus0.out_trans_id,
                         bus0.out_is_read, bus0.out_is_locked, bus0.out_type_err,
                         src[i], t[i], id[i], rd[i], lk[i], er[i]);
            end
            pop0();
        end
    endtask

    task automatic test_fill_hold;
        logic [63:0] h;
        for (int i = 0; i < 4; i++) send_hdr(mk(8'h10 + 8'(i), PACKETRESPTYPEWRITE, 8'(i), 8'h00));
        checks++;
        if (bus0.occupancy !== 3'd4) begin errors++; $display("FAIL fill_occupancy: got %0d, required 4", bus0.occupancy); end
        h = mk(8'h14, PACKETRESPTYPEWRITE, 8'd4, 8'h00);
        send_flit({h[29:0], 2'b01});
        bus0.hdr_valid = 1'b1;
        bus0.hdr_flit  = {h[59:30], 2'b10};
        #1;
        checks++;
        if (bus0.hdr_ready !== 1'b0) begin errors++; $display("FAIL full_hdr_ready: got %b, required 0", bus0.hdr_ready); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (bus0.hdr_ready !== 1'b0 || bus0.occupancy !== 3'd4 || bus0.out_trans_id !== 8'd0) begin
                errors++;
                $display("FAIL hold_%0d: hdr_ready=%b occupancy=%0d id=%h, required 0/4/00", c, bus0.hdr_ready, bus0.occupancy, bus0.out_trans_id);
            end
        end
        bus0.out_ready = 1'b1;
        #1;
        checks++;
        if (bus0.hdr_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready: got %b, required 1", bus0.hdr_ready); end
        tick();
        bus0.hdr_valid = 1'b0;
        bus0.out_ready = 1'b0;
        checks++;
        if (bus0.occupancy !== 3'd4 || bus0.out_trans_id !== 8'd1) begin
            errors++; $display("FAIL full_push_pop: occupancy=%0d id=%h, required 4/01", bus0.occupancy, bus0.out_trans_id);
        end
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (bus0.out_trans_id !== 8'(i) || bus0.out_source !== 8'h10 + 8'(i)) begin
                errors++;
                $display("FAIL drain_%0d: id=%h src=%h, required %h/%h", i, bus0.out_trans_id, bus0.out_source, 8'(i), 8'h10 + 8'(i));
            end
            pop0();
        end
        checks++;
        if (bus0.occupancy !== 3'd0) begin errors++; $display("FAIL drain_empty: occupancy=%0d, required 0", bus0.occupancy); end
    endtask

    task automatic test_abort;
        logic [63:0] ha;
        logic [63:0] hb;
        ha = mk(8'h55, PACKETRESPTYPEREAD, 8'hEE, 8'h77);
        hb = mk(8'h66, PACKETRESPTYPEWRITE, 8'h3C, 8'h22);
        send_flit({ha[29:0], 2'b01});
        bus0.abort     = 1'b1;
        bus0.hdr_valid = 1'b1;
        bus0.hdr_flit  = {hb[29:0], 2'b01};
        #1;
        checks++;
        if (bus0.hdr_ready !== 1'b0) begin errors++; $display("FAIL abort_hdr_ready: got %b, required 0", bus0.hdr_ready); end
        tick();
        bus0.abort     = 1'b0;
        bus0.hdr_valid = 1'b0;
        checks++;
        if (bus0.occupancy !== 3'd0) begin errors++; $display("FAIL abort_occupancy: got %0d, required 0", bus0.occupancy); end
        send_hdr(hb);
        checks++;
        if (bus0.occupancy !== 3'd1 || bus0.out_source !== 8'h66 || bus0.out_trans_id !== 8'h3C || bus0.out_is_read !== 1'b0) begin
            errors++;
            $display("FAIL abort_new_hdr: occ=%0d src=%h id=%h rd=%b, required 1/66/3c/0", bus0.occupancy, bus0.out_source, bus0.out_trans_id, bus0.out_is_read);
        end
        pop0();
        checks++;
        if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL abort_stray: out_valid=%b, required 0", bus0.out_valid); end
    endtask

    task automatic test_reset_mid;
        logic [63:0] h;
        send_hdr(mk(8'h01, PACKETRESPTYPEREAD, 8'h01, 8'h00));
        send_hdr(mk(8'h02, PACKETRESPTYPEREAD, 8'h02, 8'h00));
        h = mk(8'h03, PACKETRESPTYPEREAD, 8'h03, 8'h00);
        send_flit({h[29:0], 2'b01});
        checks++;
        if (bus0.occupancy !== 3'd2) begin errors++; $display("FAIL premid_occupancy: got %0d, required 2", bus0.occupancy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus0.out_valid !== 1'b0 || bus0.occupancy !== 3'd0 || bus0.hdr_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: out_valid=%b occ=%0d hdr_ready=%b, required 0/0/1", bus0.out_valid, bus0.occupancy, bus0.hdr_ready);
        end
        send_hdr(mk(8'h5A, PACKETRESPTYPEEXREAD, 8'h99, 8'h00));
        checks++;
        if (bus0.occupancy !== 3'd1 || bus0.out_source !== 8'h5A || bus0.out_trans_id !== 8'h99 ||
            bus0.out_is_read !== 1'b1 || bus0.out_is_locked !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_hdr: occ=%0d src=%h id=%h rd=%b lk=%b, required 1/5a/99/1/1",
                     bus0.occupancy, bus0.out_source, bus0.out_trans_id, bus0.out_is_read, bus0.out_is_locked);
        end
        pop0();
    endtask

    task automatic test_sweep;
        item_t       cur;
        item_t       e;
        logic [63:0] h;
        logic        exp_ready;
        logic        exp_rd;
        logic        exp_lk;
        logic        exp_er;
        int          sent = 0;
        int          got = 0;
        int          cyc = 0;
        cur = '{src: 8'($urandom), t: 3'($urandom_range(0, 7)), id: 8'($urandom), route: 8'($urandom)};
        while ((sent < 100 || got < 100) && cyc < 3000) begin
            checks++;
            if (int'(bus1.occupancy) !== sb.size() || bus1.out_valid !== (sb.size() != 0)) begin
                errors++;
                $display("FAIL sweep_occ_c%0d: occ=%0d valid=%b, required %0d/%b", cyc, bus1.occupancy, bus1.out_valid, sb.size(), sb.size() != 0);
            end
            h = mk(cur.src, cur.t, cur.id, cur.route);
            bus1.hdr_valid = (sent < 100);
            bus1.hdr_flit  = {h[61:0], 2'b11};
            bus1.out_ready = 1'($urandom_range(0, 1));
            #1;
            if (sent < 100) begin
                exp_ready = (sb.size() < 8) || bus1.out_ready;
                checks++;
                if (bus1.hdr_ready !== exp_ready) begin
                    errors++; $display("FAIL sweep_ready_c%0d: got %b, required %b", cyc, bus1.hdr_ready, exp_ready);
                end
            end
            if (bus1.out_valid && bus1.out_ready && sb.size() != 0) begin
                e      = sb.pop_front();
                exp_rd = (e.t == PACKETRESPTYPEREAD) || (e.t == PACKETRESPTYPEEXREAD);
                exp_lk = (e.t == PACKETRESPTYPEEXREAD) || (e.t == PACKETRESPTYPEEXWRITE);
                exp_er = !(e.t inside {PACKETRESPTYPEREAD, PACKETRESPTYPEEXREAD, PACKETRESPTYPEWRITE, PACKETRESPTYPEEXWRITE});
                checks++;
                if (bus1.out_source !== e.src || bus1.out_resp_type !== e.t || bus1.out_trans_id !== e.id ||
                    bus1.out_is_read !== exp_rd || bus1.out_is_locked !== exp_lk || bus1.out_type_err !== exp_er) begin
                    errors++;
                    $display("FAIL sweep_item_%0d: src=%h t=%0d id=%h rd=%b lk=%b err=%b, required %h/%0d/%h/%b/%b/%b",
                             got, bus1.out_source, bus1.out_resp_type, bus1.out_trans_id, bus1.out_is_read,
                             bus1.out_is_locked, bus1.out_type_err, e.src, e.t, e.id, exp_rd, exp_lk, exp_er);
                end
                got++;
            end
            if (bus1.hdr_valid && bus1.hdr_ready) begin
                sb.push_back(cur);
                sent++;
                cur = '{src: 8'($urandom), t: 3'($urandom_range(0, 7)), id: 8'($urandom), route: 8'($urandom)};
            end
            tick();
            cyc++;
        end
        bus1.hdr_valid = 1'b0;
        bus1.out_ready = 1'b0;
        checks++;
        if (sent != 100 || got != 100) begin
            errors++; $display("FAIL sweep_count: sent=%0d received=%0d, required 100/100", sent, got);
        end
    endtask

    initial begin
        bus0.hdr_valid = 1'b0;
        bus0.hdr_flit  = '0;
        bus0.abort     = 1'b0;
        bus0.out_ready = 1'b0;
        bus1.hdr_valid = 1'b0;
        bus1.hdr_flit  = '0;
        bus1.abort     = 1'b0;
        bus1.out_ready = 1'b0;
        test_reset();
        test_single();
        test_types();
        test_fill_hold();
        test_abort();
        test_reset_mid();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
